pim_mac_engine: RTL and testbench
=================================

// Module: pim_mac_engine
// PURPOSE
//  Responder end of the PIM chunk-dispatch handshake. It sits inside each PIM unit slot under the controller.
//  On a one-cycle valid, it captures an A sub-chunk [CHUNK_SIZE][PIM_UNIT_CAPACITY] and a B sub-chunk
//  [PIM_UNIT_CAPACITY][CHUNK_SIZE]. It computes their CHUNK_SIZE x CHUNK_SIZE partial product with one
//  serial MAC, then returns the product with a one-cycle result_valid pulse. The controller accumulates
//  these partials across sub-chunks.
// PARAMETERS
//  ID                 0   instance index; for debug/display only, no functional effect
//  WIDTH              16  element width, unsigned
//  CHUNK_SIZE         2   output tile edge; result has CHUNK_SIZE**2 elements
//  PIM_UNIT_CAPACITY  4   inner (k) dimension per sub-chunk
// PORTS
//  clk           in   1                                clock
//  rst           in   1                                synchronous, active-high reset
//  valid         in   1                                1-cycle request; operands valid in the same cycle
//  matrixA       in   WIDTH x [CHUNK_SIZE][PIM_UNIT_CAPACITY]   A sub-chunk, unpacked array
//  matrixB       in   WIDTH x [PIM_UNIT_CAPACITY][CHUNK_SIZE]   B sub-chunk, unpacked array
//  result        out  WIDTH x [CHUNK_SIZE**2]          row-major tile; result[i*CHUNK_SIZE+j]
//  result_valid  out  1                                1-cycle pulse; result is valid in that cycle
//  busy          out  1                                high whenever state != IDLE
// BEHAVIOUR
//  Reset values:
//   - state = IDLE
//   - every result element = 0; result_valid = 0; busy = 0
//   - internal operand copies, scratch tile, accumulator and i/j/k counters = 0
//  FSM states: IDLE, COMPUTE, DONE.
//   - IDLE: on valid=1, register a full copy of matrixA and matrixB, clear i/j/k and the accumulator,
//     then go to COMPUTE. On valid=0, stay in IDLE.
//   - COMPUTE: one MAC per cycle: prod = A[i][k]*B[k][j], truncated to WIDTH.
//     - If k < CAP-1: acc <= acc + prod; k <= k + 1.
//     - If k == CAP-1: scratch[i*CS+j] <= acc + prod; acc <= 0; k <= 0; advance j, and when j wraps,
//       advance i.
//     - Iteration order: k fastest, then j, then i.
//     - After the element i = j = CS-1, k = CAP-1 completes, copy the whole scratch tile to result
//       (including the final element) and go to DONE.
//   - DONE: result_valid = 1 for exactly this cycle, then IDLE unconditionally.
//  Latency: valid sampled in cycle T gives result_valid high in cycle T + 1 + CS*CS*CAP.
//   With default parameters this is T + 17.
//  Handshake and output rules:
//   - valid is only honoured in IDLE. valid in COMPUTE or DONE is ignored: no capture, no queueing,
//     no error.
//   - Operand ports may change freely after the capture cycle, because computation uses the captured
//     copy only.
//   - result changes only on the DONE entry edge. It holds its value through IDLE and through the
//     following COMPUTE until the next completion.
//   - The earliest next request is the cycle after DONE (IDLE); that request is accepted.
//  Arithmetic:
//   - Unsigned, modulo 2**WIDTH. Products and sums are truncated to WIDTH, with no saturation and no
//     overflow flag.
//  Boundary conditions:
//   - CAP = 1: each element takes a single COMPUTE cycle.
//   - CS = 1: the tile has a single element; latency = 1 + CAP.
//   - Counter widths are $clog2 with a minimum of 1 bit. All counters wrap back to 0 after their
//     maximum value.
//   - rst during COMPUTE or DONE: return to IDLE next cycle, result = 0, and no result_valid pulse is
//     emitted for the aborted request.
//   - rst and valid together: rst wins and nothing is captured.
// TESTING (defaults WIDTH=16, CS=2, CAP=4)
//  1. A={{1,2,3,4},{5,6,7,8}}, B rows {1,1},{1,2},{1,3},{1,4}, valid at cycle T
//     -> result_valid only at T+17; result = {10,30,26,70}; busy high T+1..T+17.
//  2. All A and B elements = 16'hFFFF -> every result element = 16'h0004 (modulo wrap).
//  3. Pulse valid at T+5 and T+17 during request 1 with different operands
//     -> both ignored; request 1 output unchanged; exactly one pulse.
//  4. Back-to-back: second valid at T+18 with A = B = 0 -> result stays {10,30,26,70} until T+35,
//     then becomes all 0 with a pulse at T+35.
//  5. Assert rst at T+8 of a request -> no pulse; result = 0, busy = 0 from T+9.
//     A new valid at T+10 completes normally at T+27.
//  6. Change matrixA/matrixB every cycle after capture -> result equals the product of the captured
//     values.

Source files
------------

// File: rtl/pim_mac_engine.sv
// PIM unit responder: captures an A/B sub-chunk pair, computes the CS x CS partial
// product with one serial MAC and returns it with a single-cycle result_valid pulse.
module pim_mac_engine #(
  parameter int ID                = 0,
  parameter int WIDTH             = 16,
  parameter int CHUNK_SIZE        = 2,
  parameter int PIM_UNIT_CAPACITY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [WIDTH-1:0] matrixA [CHUNK_SIZE][PIM_UNIT_CAPACITY],
  input  logic [WIDTH-1:0] matrixB [PIM_UNIT_CAPACITY][CHUNK_SIZE],
  output logic [WIDTH-1:0] result  [CHUNK_SIZE*CHUNK_SIZE],
  output logic             result_valid,
  output logic             busy
);

  localparam int CS  = CHUNK_SIZE;
  localparam int CAP = PIM_UNIT_CAPACITY;
  localparam int N   = CS * CS;
  localparam int IW  = (CS  > 1) ? $clog2(CS)  : 1;
  localparam int KW  = (CAP > 1) ? $clog2(CAP) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q     [CS][CAP];
  logic [WIDTH-1:0] b_q     [CAP][CS];
  logic [WIDTH-1:0] scratch [N];
  logic [WIDTH-1:0] acc, prod, sum;
  logic [IW-1:0]    i, j;
  logic [KW-1:0]    k;
  logic             last_k, last_j, last_i, tile_done;
  int               idx;

  always_comb begin
    prod      = WIDTH'(a_q[i][k] * b_q[k][j]);
    sum       = acc + prod;
    last_k    = (k == KW'(CAP - 1));
    last_j    = (j == IW'(CS - 1));
    last_i    = (i == IW'(CS - 1));
    tile_done = last_k && last_j && last_i;
    idx       = int'(i) * CS + int'(j);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid) state_nxt = COMPUTE;
      COMPUTE: if (tile_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < CS; r++)
        for (int c = 0; c < CAP; c++) begin
          a_q[r][c] <= '0;
          b_q[c][r] <= '0;
        end
      for (int e = 0; e < N; e++) begin
        scratch[e] <= '0;
        result[e]  <= '0;
      end
      acc <= '0;
      i   <= '0;
      j   <= '0;
      k   <= '0;
    end else begin
      case (state)
        IDLE: if (valid) begin
          a_q <= matrixA;
          b_q <= matrixB;
          acc <= '0;
          i   <= '0;
          j   <= '0;
          k   <= '0;
        end
        COMPUTE: begin
          if (!last_k) begin
            acc <= sum;
            k   <= k + 1'b1;
          end else begin
            scratch[idx] <= sum;
            acc          <= '0;
            k            <= '0;
            j            <= last_j ? '0 : j + 1'b1;
            if (last_j) i <= last_i ? '0 : i + 1'b1;
            // Final element bypasses scratch so the tile publishes in one edge.
            if (tile_done)
              for (int e = 0; e < N; e++)
                result[e] <= (e == idx) ? sum : scratch[e];
          end
        end
        default: ;
      endcase
    end
  end

  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_pim_mac_engine.sv
// Directed + randomized bench for pim_mac_engine: checks latency, pulse shape,
// result hold, ignored requests, reset abort and operand capture against a matrix model.
module tb_pim_mac_engine;

  localparam int W   = 16;
  localparam int CS  = 2;
  localparam int CAP = 4;
  localparam int N   = CS * CS;
  localparam int LAT = 1 + CS * CS * CAP;

  typedef logic [W-1:0] ma_t  [CS][CAP];
  typedef logic [W-1:0] mb_t  [CAP][CS];
  typedef logic [W-1:0] res_t [N];

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0;
  ma_t          matrixA;
  mb_t          matrixB;
  logic [W-1:0] result [N];
  logic         result_valid, busy;

  int tests = 0;
  int fails = 0;

  pim_mac_engine #(.ID(0), .WIDTH(W), .CHUNK_SIZE(CS), .PIM_UNIT_CAPACITY(CAP)) dut (
    .clk(clk), .rst(rst), .valid(valid), .matrixA(matrixA), .matrixB(matrixB),
    .result(result), .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_res(input string tag, input res_t exp);
    bit ok;
    ok = 1'b1;
    for (int e = 0; e < N; e++) if (result[e] !== exp[e]) ok = 1'b0;
    tests++;
    assert (ok) else begin
      fails++;
      $error("FAIL %s: got {%0h,%0h,%0h,%0h}, expected {%0h,%0h,%0h,%0h}", tag,
             result[0], result[1], result[2], result[3], exp[0], exp[1], exp[2], exp[3]);
    end
  endtask

  // Plain matrix product; the mod-2^W wrap of the full sum equals stepwise truncation.
  function automatic res_t model(input ma_t a, input mb_t b);
    res_t        r;
    int unsigned s;
    for (int ii = 0; ii < CS; ii++)
      for (int jj = 0; jj < CS; jj++) begin
        s = 0;
        for (int kk = 0; kk < CAP; kk++) s += int'(a[ii][kk]) * int'(b[kk][jj]);
        r[ii*CS+jj] = W'(s);
      end
    return r;
  endfunction

  task automatic rand_ops(output ma_t a, output mb_t b);
    for (int r = 0; r < CS; r++)
      for (int c = 0; c < CAP; c++) begin
        a[r][c] = W'($urandom);
        b[c][r] = W'($urandom);
      end
  endtask

  // Issues one request now and walks it to the idle cycle after DONE.
  task automatic run(input ma_t a, input mb_t b, input res_t prev,
                     input bit junk, input bit scramble, input string tag);
    res_t exp;
    ma_t  ja;
    mb_t  jb;
    exp     = model(a, b);
    matrixA = a;
    matrixB = b;
    valid   = 1'b1;
    cyc();
    valid = 1'b0;
    for (int n = 1; n <= LAT; n++) begin
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " pulse"}, 32'(result_valid), 32'(n == LAT));
      if (n < LAT) chk_res({tag, " hold"}, prev);
      else         chk_res({tag, " result"}, exp);
      valid = junk && (n == 5 || n == LAT);
      if (valid || scramble) begin
        rand_ops(ja, jb);
        matrixA = ja;
        matrixB = jb;
      end
      cyc();
    end
    valid = 1'b0;
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " idle pulse"}, 32'(result_valid), 32'd0);
    chk_res({tag, " idle hold"}, exp);
  endtask

  initial begin
    ma_t  a, a1, zf, ff;
    mb_t  b, b1, zb, fb;
    res_t zero, last;

    for (int e = 0; e < N; e++) zero[e] = '0;
    for (int r = 0; r < CS; r++)
      for (int c = 0; c < CAP; c++) begin
        zf[r][c] = '0;
        zb[c][r] = '0;
        ff[r][c] = '1;
        fb[c][r] = '1;
      end
    a1 = '{'{16'd1, 16'd2, 16'd3, 16'd4}, '{16'd5, 16'd6, 16'd7, 16'd8}};
    b1 = '{'{16'd1, 16'd1}, '{16'd1, 16'd2}, '{16'd1, 16'd3}, '{16'd1, 16'd4}};
    matrixA = zf;
    matrixB = zb;

    // reset state
    rst = 1'b1;
    cyc();
    cyc();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset pulse", 32'(result_valid), 32'd0);
    chk_res("reset result", zero);
    rst = 1'b0;
    cyc();
    chk("post-reset busy", 32'(busy), 32'd0);

    // directed tile with ignored requests at T+5 and T+17
    run(a1, b1, zero, 1'b1, 1'b0, "t1");
    last = model(a1, b1);
    chk("t1 elem0", 32'(result[0]), 32'd10);
    chk("t1 elem3", 32'(result[3]), 32'd70);

    // back-to-back zero request, issued in the cycle after DONE
    run(zf, zb, last, 1'b0, 1'b0, "t4");
    last = zero;

    // all-ones wrap
    run(ff, fb, last, 1'b0, 1'b0, "t2");
    chk("t2 elem1", 32'(result[1]), 32'h4);
    last = model(ff, fb);

    // reset abort at T+8
    rand_ops(a, b);
    matrixA = a;
    matrixB = b;
    valid   = 1'b1;
    cyc();
    valid = 1'b0;
    repeat (7) cyc();
    chk("t5 busy before abort", 32'(busy), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t5 abort busy", 32'(busy), 32'd0);
    chk("t5 abort pulse", 32'(result_valid), 32'd0);
    chk_res("t5 abort result", zero);
    cyc();
    chk("t5 idle pulse", 32'(result_valid), 32'd0);
    chk("t5 idle busy", 32'(busy), 32'd0);
    rand_ops(a, b);
    run(a, b, zero, 1'b0, 1'b0, "t5 restart");
    last = model(a, b);

    // rst together with valid captures nothing
    rand_ops(a, b);
    matrixA = a;
    matrixB = b;
    rst     = 1'b1;
    valid   = 1'b1;
    cyc();
    rst   = 1'b0;
    valid = 1'b0;
    chk("rst+valid busy", 32'(busy), 32'd0);
    chk_res("rst+valid result", zero);
    cyc();
    chk("rst+valid no capture", 32'(busy), 32'd0);
    last = zero;

    // randomized back-to-back with operand scrambling after capture
    for (int t = 0; t < 20; t++) begin
      rand_ops(a, b);
      run(a, b, last, t[0], 1'b1, "rand");
      last = model(a, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
